mul_slave: RTL and testbench
============================

Name: mul_slave

Overview:
- Bus slave at 0x0100–0x01FF, directly downstream of the single-master bus.
- Receives the bus outputs s_sel, s_wr, s_addr and s_din, and returns s_dout.
- Contains memory-mapped operand, control and status registers plus a sequential radix-2 shift-add unsigned multiplier (32x32 -> 64).
- Raises an interrupt on completion when enabled.

Parameters:
- OP_W, default 32: operand width; the result is 2*OP_W. Only 32 is supported, because the bus write path is 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- s_sel  in  1  slave select from the bus address decoder
- s_wr  in  1  1 = write, 0 = read (registered in the bus)
- s_addr  in  16  registered address; offset = s_addr[7:0]
- s_din  in  64  write data; only [31:0] is used
- s_dout  out  64  read data, combinational from s_addr
- m_interrupt  out  1  completion interrupt, level

Behaviour:
- Register map (offset = s_addr[7:0]):
  - 0x00 OPA: RW, 32 bits.
  - 0x01 OPB: RW, 32 bits.
  - 0x02 CTRL: write-only. bit0 = start, bit1 = clear. Both are one-shot pulses and are not stored. Reads return 0.
  - 0x03 INTR_EN: RW, bit0 only.
  - 0x04 STATUS: read-only. bit0 = busy, bit1 = done.
  - 0x05 RESULT: read-only, 64 bits.
  - All other offsets: reads return 0, writes are ignored.
- Write: when s_sel=1 and s_wr=1, the target register updates on the next rising clk edge.
- Read path:
  - s_dout is zero-extended and combinational.
  - s_dout = register(offset) when s_sel=1 and s_wr=0; otherwise 64'h0.
  - The bus samples s_dout on the same edge it sees s_sel, so no wait states are allowed.
- Reset (async, reset_n=0):
  - OPA, OPB, INTR_EN, RESULT, counter and multiplicand/multiplier shadows all go to 0.
  - State goes to IDLE.
  - m_interrupt=0 and s_dout=0 immediately.
- FSM states: IDLE, EXEC, DONE.
  - IDLE:
    - A start write latches OPA into the multiplicand shadow (zero-extended to 64) and OPB into the multiplier shadow.
    - RESULT is cleared, counter=0, next state EXEC.
  - EXEC, each cycle:
    - If multiplier[0]=1, RESULT += multiplicand (64-bit, no overflow possible).
    - multiplicand <<= 1, multiplier >>= 1, counter++.
    - When counter==31 (the 32nd iteration), next state is DONE.
    - This is exactly 32 EXEC cycles; there is no early exit on a zero multiplier.
  - DONE: holds RESULT. A start write re-enters EXEC with fresh operands.
  - STATUS: busy = (state==EXEC); done = (state==DONE).
- Latency: start is sampled at edge T. STATUS reads busy=1 from T through T+31. done=1 and RESULT is final after edge T+32.
- Clear (CTRL bit1), any state, next edge:
  - State -> IDLE, RESULT=0, counter=0.
  - OPA, OPB and INTR_EN are retained.
- Start and clear in the same write: clear wins, and start is ignored.
- Start while in EXEC: ignored. The computation continues unchanged.
- OPA/OPB writes while in EXEC: the registers update, but the running computation uses its shadows. The new values apply at the next start.
- m_interrupt = (state==DONE) & INTR_EN[0], registered-state based and glitch-free.
  - It clears on a clear write, on a start that leaves DONE, or on writing INTR_EN=0.
- reset_n asserted mid-EXEC: immediate abort to the reset values. No partial result is retained.
- s_sel=0: no register changes, s_dout=0, and the FSM keeps running.

Test Plan:
- Reset: hold reset_n=0 while busy -> all readable registers 0, m_interrupt=0, s_dout=0. After release, STATUS=0.
- Basic multiply: write OPA=0x0000_000C, OPB=0x0000_000A, INTR_EN=1, CTRL=0x1 -> STATUS=0x1 for 32 cycles, then 0x2 and m_interrupt=1. RESULT reads 0x0000_0000_0000_0078.
- Max operands: OPA=OPB=0xFFFF_FFFF, start -> RESULT=0xFFFF_FFFE_0000_0001 exactly 32 cycles after the start edge. OPB=0 gives RESULT=0, still after 32 cycles.
- Start during EXEC, plus an OPA write mid-EXEC (OPA 3->7, OPB=5) -> RESULT=0x0F, and DONE timing is unchanged. A following start gives 0x23.
- Clear mid-EXEC at cycle 10 -> STATUS=0, RESULT=0, m_interrupt stays 0. CTRL=0x3 while in DONE -> IDLE, not restarted.
- Address edges: read offsets 0x06 and 0xFF -> 0. Write 0x04/0x05 -> no effect. s_sel=0 with s_wr=1 -> no register change and s_dout=0.

Source files
------------

// File: rtl/mul_slave.sv
// mul_slave: memory-mapped 32x32->64 sequential shift-add multiplier.
// Bus window 0x0100-0x01FF; only the low address byte is decoded here.
// Reads are zero-wait combinational; writes land on the next clk edge.
module mul_slave #(
  parameter int OP_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        m_interrupt
);

  localparam int RES_W = 2 * OP_W;
  localparam int CNT_W = $clog2(OP_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h01;
  localparam logic [7:0] OFF_CTRL   = 8'h02;
  localparam logic [7:0] OFF_IEN    = 8'h03;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_RESULT = 8'h05;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state;
  logic [OP_W-1:0]   opa, opb;
  logic              intr_en;
  logic [RES_W-1:0]  result;
  logic [RES_W-1:0]  mcand;
  logic [OP_W-1:0]   mplier;
  logic [CNT_W-1:0]  cnt;

  logic [7:0] off;
  logic       wr_en, start, clr;
  logic       unused_bits;

  assign off   = s_addr[7:0];
  assign wr_en = s_sel & s_wr;
  // Both CTRL bits are pulses derived from the write cycle itself; nothing stored.
  assign clr   = wr_en && (off == OFF_CTRL) && s_din[1];
  assign start = wr_en && (off == OFF_CTRL) && s_din[0] && !s_din[1];

  // Upper data bits and the window byte are decoded upstream.
  assign unused_bits = ^{s_din[63:OP_W], s_addr[15:8]};

  // Software-visible operand and interrupt-enable registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa     <= '0;
      opb     <= '0;
      intr_en <= 1'b0;
    end else if (wr_en) begin
      case (off)
        OFF_OPA: opa     <= s_din[OP_W-1:0];
        OFF_OPB: opb     <= s_din[OP_W-1:0];
        OFF_IEN: intr_en <= s_din[0];
        default: ;
      endcase
    end
  end

  // Multiplier FSM: start latches operand shadows, then exactly OP_W
  // shift-add iterations; later operand writes only affect the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      result <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (clr) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= {{OP_W{1'b0}}, opa};
            mplier <= opb;
            result <= '0;
            cnt    <= '0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (mplier[0]) result <= result + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Interrupt is a pure AND of two flops, so it cannot glitch.
  assign m_interrupt = (state == DONE) && intr_en;

  // Zero-wait read mux; anything but a selected read returns zero.
  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (off)
        OFF_OPA:    s_dout = {{(64-OP_W){1'b0}}, opa};
        OFF_OPB:    s_dout = {{(64-OP_W){1'b0}}, opb};
        OFF_IEN:    s_dout = {63'b0, intr_en};
        OFF_STATUS: s_dout = {62'b0, state == DONE, state == EXEC};
        OFF_RESULT: s_dout = result;
        default:    s_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_slave.sv
// Directed bench for mul_slave with a cycle-count/product reference model.
module tb_mul_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_wr = 1'b0;
  logic [15:0] s_addr = 16'h0100;
  logic [63:0] s_din = '0;
  logic [63:0] s_dout;
  logic        m_interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  mul_slave #(.OP_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .m_interrupt(m_interrupt)
  );

  always #5 clk = ~clk;

  // Reference model: operands, a countdown of EXEC cycles left, and the
  // arithmetic product that must show up once the countdown ends.
  logic [31:0] m_opa = '0, m_opb = '0;
  logic        m_ien = 1'b0, m_done = 1'b0;
  logic [63:0] m_res = '0, m_pend = '0;
  int          m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_opa <= '0; m_opb <= '0; m_ien <= 1'b0; m_done <= 1'b0;
      m_res <= '0; m_pend <= '0; m_left <= 0;
    end else begin
      if (s_sel && s_wr) begin
        case (s_addr[7:0])
          8'h00: m_opa <= s_din[31:0];
          8'h01: m_opb <= s_din[31:0];
          8'h03: m_ien <= s_din[0];
          default: ;
        endcase
      end
      if (s_sel && s_wr && s_addr[7:0] == 8'h02 && s_din[1]) begin
        m_left <= 0; m_done <= 1'b0; m_res <= '0;
      end else if (s_sel && s_wr && s_addr[7:0] == 8'h02 && s_din[0] && m_left == 0) begin
        m_left <= 32; m_done <= 1'b0; m_res <= '0;
        m_pend <= 64'(m_opa) * 64'(m_opb);
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read();
    if (!(s_sel && !s_wr)) return 64'h0;
    case (s_addr[7:0])
      8'h00: return {32'h0, m_opa};
      8'h01: return {32'h0, m_opb};
      8'h03: return {63'h0, m_ien};
      8'h04: return {62'h0, m_done, m_left > 0};
      8'h05: return m_res;
      default: return 64'h0;
    endcase
  endfunction

  // Every-cycle comparison; RESULT is only defined outside EXEC.
  always @(negedge clk) begin
    if (!(s_sel && !s_wr && s_addr[7:0] == 8'h05 && m_left > 0))
      check("model_dout", s_dout, model_read());
    check("model_irq", {63'h0, m_interrupt}, {63'h0, m_done & m_ien});
  end

  task automatic drive(input logic sel, input logic wr, input logic [7:0] off, input logic [63:0] d);
    s_sel = sel; s_wr = wr; s_addr = {8'h01, off}; s_din = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [63:0] d);
    drive(1'b1, 1'b1, off, d);
    step();
  endtask

  task automatic rd_reg(input logic [7:0] off, input logic [63:0] exp, input string nm);
    drive(1'b1, 1'b0, off, 64'h0);
    @(negedge clk);
    check(nm, s_dout, exp);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held low
    drive(1'b1, 1'b0, 8'h04, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout", s_dout, 64'h0);
    check("rst_irq", {63'h0, m_interrupt}, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_sel = 1'b0;
    rd_reg(8'h04, 64'h0, "status_after_reset");

    // Basic multiply: 12 * 10, busy for exactly 32 reads
    wr_reg(8'h00, 64'h0000_000C);
    wr_reg(8'h01, 64'h0000_000A);
    wr_reg(8'h03, 64'h1);
    wr_reg(8'h02, 64'h1);
    for (int i = 0; i < 32; i++) rd_reg(8'h04, 64'h1, "basic_busy");
    rd_reg(8'h04, 64'h2, "basic_done");
    check("basic_irq", {63'h0, m_interrupt}, 64'h1);
    rd_reg(8'h05, 64'h78, "basic_result");

    // Max operands; start from DONE drops the interrupt
    wr_reg(8'h00, 64'hFFFF_FFFF);
    wr_reg(8'h01, 64'hFFFF_FFFF);
    wr_reg(8'h02, 64'h1);
    check("restart_irq_low", {63'h0, m_interrupt}, 64'h0);
    idle(31);
    rd_reg(8'h04, 64'h1, "max_busy_last");
    rd_reg(8'h05, 64'hFFFF_FFFE_0000_0001, "max_result");
    rd_reg(8'h04, 64'h2, "max_done");

    // Zero multiplier still takes 32 cycles
    wr_reg(8'h01, 64'h0);
    wr_reg(8'h02, 64'h1);
    idle(31);
    rd_reg(8'h04, 64'h1, "zero_busy_last");
    rd_reg(8'h05, 64'h0, "zero_result");
    rd_reg(8'h04, 64'h2, "zero_done");

    // Start and OPA write during EXEC are ignored by the running multiply
    wr_reg(8'h00, 64'h3);
    wr_reg(8'h01, 64'h5);
    wr_reg(8'h02, 64'h1);
    idle(3);
    wr_reg(8'h02, 64'h1);
    wr_reg(8'h00, 64'h7);
    idle(26);
    rd_reg(8'h04, 64'h1, "mid_busy_last");
    rd_reg(8'h05, 64'h0F, "mid_result");
    wr_reg(8'h02, 64'h1);
    idle(31);
    rd_reg(8'h04, 64'h1, "second_busy_last");
    rd_reg(8'h05, 64'h23, "second_result");

    // Read-only offsets ignore writes; unmapped offsets read zero
    wr_reg(8'h05, 64'hFFFF_FFFF_FFFF_FFFF);
    wr_reg(8'h04, 64'h0);
    rd_reg(8'h05, 64'h23, "ro_result");
    rd_reg(8'h04, 64'h2, "ro_status");
    rd_reg(8'h06, 64'h0, "unmapped_06");
    rd_reg(8'hFF, 64'h0, "unmapped_ff");
    rd_reg(8'h02, 64'h0, "ctrl_reads_zero");
    drive(1'b0, 1'b1, 8'h00, 64'h1234);
    @(negedge clk);
    check("nosel_dout", s_dout, 64'h0);
    step();
    rd_reg(8'h00, 64'h7, "nosel_opa");

    // Clear at EXEC cycle 10
    wr_reg(8'h02, 64'h1);
    idle(9);
    wr_reg(8'h02, 64'h2);
    rd_reg(8'h04, 64'h0, "clr_status");
    rd_reg(8'h05, 64'h0, "clr_result");
    check("clr_irq", {63'h0, m_interrupt}, 64'h0);
    idle(40);
    check("clr_irq_stays", {63'h0, m_interrupt}, 64'h0);

    // Start+clear in DONE: goes idle, does not restart
    wr_reg(8'h02, 64'h1);
    idle(32);
    rd_reg(8'h04, 64'h2, "pre_sc_done");
    wr_reg(8'h02, 64'h3);
    rd_reg(8'h04, 64'h0, "sc_status");
    idle(2);
    rd_reg(8'h04, 64'h0, "sc_status_later");
    rd_reg(8'h00, 64'h7, "sc_opa_kept");
    rd_reg(8'h03, 64'h1, "sc_ien_kept");

    // Disabling INTR_EN drops the interrupt while DONE
    wr_reg(8'h02, 64'h1);
    idle(32);
    check("ien_irq_high", {63'h0, m_interrupt}, 64'h1);
    wr_reg(8'h03, 64'h0);
    check("ien_irq_low", {63'h0, m_interrupt}, 64'h0);
    rd_reg(8'h05, 64'h23, "ien_result");

    // Async reset mid-EXEC
    wr_reg(8'h03, 64'h1);
    wr_reg(8'h02, 64'h1);
    idle(5);
    drive(1'b1, 1'b0, 8'h00, 64'h0);
    reset_n = 1'b0;
    #1;
    check("arst_dout", s_dout, 64'h0);
    @(negedge clk);
    check("arst_irq", {63'h0, m_interrupt}, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_sel = 1'b0;
    rd_reg(8'h04, 64'h0, "arst_status");
    rd_reg(8'h00, 64'h0, "arst_opa");
    rd_reg(8'h05, 64'h0, "arst_result");
    rd_reg(8'h03, 64'h0, "arst_ien");
    idle(40);
    rd_reg(8'h04, 64'h0, "arst_no_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
